// File: rtl/lfsr_chk_pkg.sv
// rtl/lfsr_chk_pkg.sv - shared constants, state encoding and next-state function for the LFSR checker
//
// Contents:
//   LFSR_W       word width of the checked sequence (16)
//   LFSR_TAPS    Fibonacci tap mask, bits 15, 13, 12, 10
//   chk_state_e  SEARCH / VERIFY / LOCKED
//   lfsr_next    one-step advance of the generator state
package lfsr_chk_pkg;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_e;

   // Feedback is the parity of the tapped bits, shifted in at the LSB.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational one-step LFSR advance
//
// Ports:
//   cur  in   LFSR_W  current state
//   nxt  out  LFSR_W  successor state
module lfsr_step
   import lfsr_chk_pkg::*;
(
   input  logic [LFSR_W-1:0] cur,
   output logic [LFSR_W-1:0] nxt
);

   assign nxt = lfsr_next(cur);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising 16-bit LFSR sequence checker with lock, error count and period
//
// Optional feature macro: LFSR_CHK_PERIOD_EN (sequence period measurement).
//
// Parameters:
//   LOCK_COUNT    consecutive correct predictions needed to declare lock
//   LOSS_COUNT    consecutive mismatches while locked that force a return to search
//   ERR_W         error counter width
// Ports:
//   clk           in   1       clock, rising edge
//   reset         in   1       asynchronous active-low reset
//   in_valid      in   1       in_data carries a word this cycle
//   in_data       in   16      received LFSR word
//   clear         in   1       synchronous clear of err_count and period measurement
//   locked        out  1       checker is in LOCKED
//   err_pulse     out  1       one-cycle pulse per mismatched word while locked
//   err_count     out  ERR_W   saturating mismatch count
//   period_valid  out  1       one-cycle pulse when a period measurement completes
//   period        out  16      last measured period in words
module lfsr_checker
   import lfsr_chk_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 8,
   parameter int ERR_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [LFSR_W-1:0] in_data,
   input  logic              clear,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output logic              period_valid,
   output logic [LFSR_W-1:0] period
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

   chk_state_e          state_q, state_d;
   logic [LFSR_W-1:0]   pred_q, pred_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic                err_pulse_d;
   logic [ERR_W-1:0]    err_count_d;
   logic                err_inc;
   logic                pred_hit;
   logic [LFSR_W-1:0]   nxt_in;
   logic [LFSR_W-1:0]   nxt_pred;

   lfsr_step u_step_in (
      .cur (in_data),
      .nxt (nxt_in)
   );

   lfsr_step u_step_pred (
      .cur (pred_q),
      .nxt (nxt_pred)
   );

   assign pred_hit = (in_data == pred_q);

   always_comb begin
      state_d     = state_q;
      pred_d      = pred_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_pulse_d = 1'b0;
      err_inc     = 1'b0;

      if (in_valid) begin
         unique case (state_q)
            SEARCH: begin
               if (in_data != '0) begin
                  pred_d  = nxt_in;
                  match_d = '0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               // Both branches seed from the received word; only the run count differs.
               pred_d = nxt_in;
               if (pred_hit) begin
                  if (int'(match_q) + 1 >= LOCK_COUNT) begin
                     match_d = '0;
                     miss_d  = '0;
                     state_d = LOCKED;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
                  if (in_data == '0) begin
                     state_d = SEARCH;
                  end
               end
            end
            LOCKED: begin
               // Flywheel: advance from our own prediction so corrupted words never reseed.
               pred_d = nxt_pred;
               if (pred_hit) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  err_inc     = 1'b1;
                  if (int'(miss_q) + 1 >= LOSS_COUNT) begin
                     miss_d  = '0;
                     state_d = SEARCH;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end
            end
            default: state_d = SEARCH;
         endcase
      end

      // clear wins over a same-cycle increment.
      err_count_d = err_count;
      if (clear) begin
         err_count_d = '0;
      end else if (err_inc && (err_count != '1)) begin
         err_count_d = err_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SEARCH;
         pred_q    <= '0;
         match_q   <= '0;
         miss_q    <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         pred_q    <= pred_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         locked    <= (state_d == LOCKED);
         err_pulse <= err_pulse_d;
         err_count <= err_count_d;
      end
   end

`ifdef LFSR_CHK_PERIOD_EN
   logic              lock_entry;
   logic              lock_loss;
   logic              meas_q;
   logic [LFSR_W-1:0] ref_word_q;
   logic [LFSR_W-1:0] pcnt_q;

   assign lock_entry = (state_q != LOCKED) && (state_d == LOCKED);
   assign lock_loss  = (state_q == LOCKED) && (state_d != LOCKED);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meas_q       <= 1'b0;
         ref_word_q   <= '0;
         pcnt_q       <= '0;
         period_valid <= 1'b0;
         period       <= '0;
      end else begin
         period_valid <= 1'b0;
         if (clear || lock_loss) begin
            meas_q <= 1'b0;
            pcnt_q <= '0;
         end else if (lock_entry) begin
            ref_word_q <= in_data;
            pcnt_q     <= '0;
            meas_q     <= 1'b1;
         end else if (in_valid && (state_q == LOCKED) && meas_q) begin
            // The reference must also agree with the flywheel so a corrupted word
            // that happens to equal ref cannot close the measurement early.
            if (pred_hit && (in_data == ref_word_q)) begin
               period_valid <= 1'b1;
               period       <= pcnt_q + 1'b1;
               pcnt_q       <= '0;
            end else if (pcnt_q == '1) begin
               meas_q <= 1'b0;
               pcnt_q <= '0;
            end else begin
               pcnt_q <= pcnt_q + 1'b1;
            end
         end
      end
   end
`else
   assign period_valid = 1'b0;
   assign period       = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data  = 16'h0000;
   logic        clear    = 1'b0;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic        period_valid;
   logic [15:0] period;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [15:0] cur;

   always #5 clk = ~clk;

   lfsr_checker #(
      .LOCK_COUNT (4),
      .LOSS_COUNT (8),
      .ERR_W      (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .clear        (clear),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .err_count    (err_count),
      .period_valid (period_valid),
      .period       (period)
   );

   function automatic logic [15:0] model_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] w, input logic c);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      clear    = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic idle(input logic c);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'hFFFF;
      clear    = c;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic send_clean();
      send(cur, 1'b0);
      cur = model_next(cur);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("rst_async_locked", {31'd0, locked}, 32'd0);
      check_eq("rst_async_errcnt", {16'd0, err_count}, 32'd0);
      check_eq("rst_async_pulse", {31'd0, err_pulse}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int pulses;
      int first_idx;
      int n_words;
      logic [15:0] first_period;

      #2 reset = 1'b0;
      #1;
      check_eq("rst_locked", {31'd0, locked}, 32'd0);
      check_eq("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      check_eq("rst_err_count", {16'd0, err_count}, 32'd0);
      check_eq("rst_period_valid", {31'd0, period_valid}, 32'd0);
      check_eq("rst_period", {16'd0, period}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Zero words in SEARCH must not seed the predictor.
      send(16'h0000, 1'b0);
      send(16'h0000, 1'b0);
      check_eq("zero_ignored", {31'd0, locked}, 32'd0);

      // Clean stream from 0xACE1: lock after the 5th word.
      cur = 16'hACE1;
      for (int i = 1; i <= 5; i++) begin
         send_clean();
         if (i == 4) check_eq("lock_w4", {31'd0, locked}, 32'd0);
         if (i == 5) check_eq("lock_w5", {31'd0, locked}, 32'd1);
      end
      for (int i = 6; i <= 99; i++) send_clean();
      check_eq("clean_errcnt", {16'd0, err_count}, 32'd0);
      check_eq("clean_locked", {31'd0, locked}, 32'd1);

      // Bit 3 flip on word 100.
      send(cur ^ 16'h0008, 1'b0);
      cur = model_next(cur);
      check_eq("flip_pulse", {31'd0, err_pulse}, 32'd1);
      check_eq("flip_errcnt", {16'd0, err_count}, 32'd1);
      check_eq("flip_locked", {31'd0, locked}, 32'd1);
      send_clean();
      check_eq("flip_next_pulse", {31'd0, err_pulse}, 32'd0);
      check_eq("flip_next_errcnt", {16'd0, err_count}, 32'd1);

      // Clear on an idle cycle.
      idle(1'b1);
      check_eq("clear_errcnt", {16'd0, err_count}, 32'd0);
      check_eq("clear_locked", {31'd0, locked}, 32'd1);

      // Loss of lock: 8 consecutive mismatches, with an idle gap in the run.
      for (int i = 1; i <= 8; i++) begin
         send(cur ^ 16'h0100, 1'b0);
         cur = model_next(cur);
         if (i == 4) idle(1'b0);
         if (i == 7) check_eq("loss_w7_locked", {31'd0, locked}, 32'd1);
         if (i == 8) begin
            check_eq("loss_w8_locked", {31'd0, locked}, 32'd0);
            check_eq("loss_w8_pulse", {31'd0, err_pulse}, 32'd1);
            check_eq("loss_w8_errcnt", {16'd0, err_count}, 32'd8);
         end
      end

      // Relock on the continuing clean stream.
      for (int i = 1; i <= 5; i++) begin
         send_clean();
         if (i == 4) check_eq("relock_w4", {31'd0, locked}, 32'd0);
         if (i == 5) check_eq("relock_w5", {31'd0, locked}, 32'd1);
      end
      check_eq("relock_errcnt", {16'd0, err_count}, 32'd8);

      // Asynchronous reset mid-run, then the first word acts as a seed.
      pulse_reset();
      for (int i = 1; i <= 5; i++) begin
         send_clean();
         if (i == 1) check_eq("post_rst_w1", {31'd0, locked}, 32'd0);
         if (i == 4) check_eq("post_rst_w4", {31'd0, locked}, 32'd0);
         if (i == 5) check_eq("post_rst_w5", {31'd0, locked}, 32'd1);
      end

      // Clear colliding with a mismatch at err_count = 5.
      for (int i = 1; i <= 5; i++) begin
         send(cur ^ 16'h0010, 1'b0);
         cur = model_next(cur);
      end
      check_eq("coll_pre_errcnt", {16'd0, err_count}, 32'd5);
      send(cur ^ 16'h0010, 1'b1);
      cur = model_next(cur);
      check_eq("coll_errcnt", {16'd0, err_count}, 32'd0);
      check_eq("coll_pulse", {31'd0, err_pulse}, 32'd1);
      check_eq("coll_locked", {31'd0, locked}, 32'd1);
      send_clean();
      check_eq("coll_next_pulse", {31'd0, err_pulse}, 32'd0);
      check_eq("coll_next_errcnt", {16'd0, err_count}, 32'd0);

      // Period measurement from a fresh lock.
      pulse_reset();
`ifdef LFSR_CHK_PERIOD_EN
      n_words = 65545;
`else
      n_words = 300;
`endif
      pulses       = 0;
      first_idx    = 0;
      first_period = 16'h0000;
      for (int i = 1; i <= n_words; i++) begin
         send_clean();
         if (period_valid) begin
            pulses++;
            if (pulses == 1) begin
               first_idx    = i;
               first_period = period;
            end
         end
      end
`ifdef LFSR_CHK_PERIOD_EN
      check_eq("period_pulses", pulses, 32'd1);
      check_eq("period_index", first_idx, 32'd65540);
      check_eq("period_value", {16'd0, first_period}, 32'd65535);
      check_eq("period_held", {16'd0, period}, 32'd65535);
`else
      check_eq("period_pulses", pulses, 32'd0);
      check_eq("period_value", {16'd0, period}, 32'd0);
`endif
      check_eq("period_run_errcnt", {16'd0, err_count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
